// File: rtl/neuron_stream_pkg.sv
// neuron_stream_pkg
// Shared definitions for the time-multiplexed neuron:
//   - unit_t / unit_signed_t number formats at the default width
//   - unit_max / unit_min range constants for unit_t
//   - neuron_stream_state_t, the evaluation FSM encoding
// Default parameter values are exported so the top and its users agree.
package neuron_stream_pkg;

    localparam int UNIT_W_DEF = 8;
    localparam int N_MAX_DEF  = 16;

    // unit_t u represents u / 2^W; unit_signed_t s represents s / 2^(W-1).
    typedef logic [UNIT_W_DEF-1:0]        unit_t;
    typedef logic signed [UNIT_W_DEF-1:0] unit_signed_t;

    localparam unit_t unit_max = '1;
    localparam unit_t unit_min = '0;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MAC       = 3'd1,
        ST_DIV_AVG   = 3'd2,
        ST_CLAMP     = 3'd3,
        ST_DIV_SCALE = 3'd4,
        ST_DONE      = 3'd5
    } neuron_stream_state_t;

endpackage

// File: rtl/neuron_stream_if.sv
// neuron_stream_if
// Bundles the input beat stream, per-evaluation configuration, the result
// handshake and the busy status of neuron_stream.
//   master: stream source / result sink (drives beats, config, out_ready)
//   slave : the neuron (drives in_ready, results, busy)
interface neuron_stream_if
    import neuron_stream_pkg::*;
#(
    parameter int UNIT_W = UNIT_W_DEF,
    parameter int N_MAX  = N_MAX_DEF
);
    localparam int CFG_W = $clog2(N_MAX + 1);

    logic              in_valid;
    logic              in_ready;
    logic [UNIT_W-1:0] in_data;
    logic [UNIT_W-1:0] in_weight;
    logic [CFG_W-1:0]  cfg_fan_in;
    logic [UNIT_W-1:0] cfg_upper;
    logic [UNIT_W-1:0] cfg_lower;
    logic              out_valid;
    logic              out_ready;
    logic [UNIT_W-1:0] out_data;
    logic [UNIT_W-1:0] out_average;
    logic              out_too_big;
    logic              out_too_small;
    logic              busy;

    modport master (
        output in_valid, in_data, in_weight, cfg_fan_in, cfg_upper, cfg_lower, out_ready,
        input  in_ready, out_valid, out_data, out_average, out_too_big, out_too_small, busy
    );

    modport slave (
        input  in_valid, in_data, in_weight, cfg_fan_in, cfg_upper, cfg_lower, out_ready,
        output in_ready, out_valid, out_data, out_average, out_too_big, out_too_small, busy
    );

endinterface

// File: rtl/neuron_stream_divider.sv
// seq_divider
// Unsigned restoring divider, one quotient bit per clock.
//   clk, rst  : clock, synchronous active-high reset
//   start     : load dividend/divisor (one cycle), begins a divide
//   dividend  : DW-bit unsigned numerator
//   divisor   : DW-bit unsigned denominator (never 0 in use)
//   quotient  : DW-bit result, valid while done is high
//   done      : one-cycle pulse after the last iteration
// Latency: the start cycle loads, then DW iterations; done follows the last.
module seq_divider #(
    parameter int DW = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          done
);
    localparam int CW = $clog2(DW + 1);

    logic [DW:0]   rem_reg;
    logic [DW-1:0] quo_reg;
    logic [DW-1:0] dsr_reg;
    logic [CW-1:0] cnt_reg;
    logic          busy_reg;
    logic          done_reg;

    logic [DW:0]   shifted;
    logic [DW:0]   trial;

    // The remainder stays below the divisor, so the top bit of the trial
    // subtraction is a clean borrow flag.
    always_comb begin
        shifted = {rem_reg[DW-1:0], quo_reg[DW-1]};
        trial   = shifted - {1'b0, dsr_reg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg  <= '0;
            quo_reg  <= '0;
            dsr_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rem_reg  <= '0;
                quo_reg  <= dividend;
                dsr_reg  <= divisor;
                cnt_reg  <= CW'(DW);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                if (!trial[DW]) begin
                    rem_reg <= trial;
                    quo_reg <= {quo_reg[DW-2:0], 1'b1};
                end else begin
                    rem_reg <= shifted;
                    quo_reg <= {quo_reg[DW-2:0], 1'b0};
                end
                cnt_reg <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_reg;
    assign done     = done_reg;

endmodule

// File: rtl/neuron_stream.sv
// neuron_stream
// Sequential neuron: accumulates up to N_MAX (input, weight) products from a
// valid/ready stream with one multiplier, divides by the fan-in, clamps the
// average against a signed window and rescales it into the unit range.
//   clk, rst : clock, synchronous active-high reset
//   bus      : neuron_stream_if.slave -- input beats (in_*), configuration
//              (cfg_*, sampled on the first beat), result handshake (out_*)
//              and busy status
module neuron_stream
    import neuron_stream_pkg::*;
#(
    parameter int UNIT_W = UNIT_W_DEF,
    parameter int N_MAX  = N_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst,
    neuron_stream_if.slave  bus
);
    localparam int ACC_W = 2 * UNIT_W + $clog2(N_MAX) + 1;
    localparam int CNT_W = $clog2(N_MAX + 1);
    localparam int EXT_W = ACC_W - UNIT_W;

    neuron_stream_state_t state_reg, state_next;

    logic signed [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]         count_reg;
    logic [CNT_W-1:0]         f_reg;
    logic signed [UNIT_W-1:0] upper_reg;
    logic signed [UNIT_W-1:0] lower_reg;
    logic signed [UNIT_W-1:0] avg_reg;
    logic [UNIT_W-1:0]        data_reg;
    logic                     too_big_reg;
    logic                     too_small_reg;
    logic                     div_launched_reg;

    logic signed [ACC_W-1:0]  product;
    logic [CNT_W-1:0]         f_first;
    logic                     beat_last;
    logic [ACC_W-1:0]         acc_mag;
    logic signed [ACC_W-1:0]  q_signed;
    logic signed [ACC_W-1:0]  q_shift;
    logic                     q_fits;
    logic signed [UNIT_W-1:0] avg_sat;
    logic                     clamp_low;
    logic                     clamp_high;
    logic                     zero_window;
    logic                     go_scale;
    logic signed [ACC_W-1:0]  scale_num;
    logic signed [ACC_W-1:0]  scale_den;
    logic [UNIT_W-1:0]        scale_sat;

    logic                     in_ready;
    logic                     out_valid;
    logic                     busy;
    logic                     div_start;
    logic [ACC_W-1:0]         div_dividend;
    logic [ACC_W-1:0]         div_divisor;
    logic [ACC_W-1:0]         div_quotient;
    logic                     div_done;

    // Unsigned input times signed weight, both widened to the accumulator.
    assign product = $signed({{EXT_W{1'b0}}, bus.in_data})
                   * $signed({{EXT_W{bus.in_weight[UNIT_W-1]}}, bus.in_weight});

    // Effective fan-in: 0 behaves as 1, anything above N_MAX as N_MAX.
    always_comb begin
        f_first = bus.cfg_fan_in;
        if (bus.cfg_fan_in == '0) begin
            f_first = CNT_W'(1);
        end else if (bus.cfg_fan_in > CNT_W'(N_MAX)) begin
            f_first = CNT_W'(N_MAX);
        end
    end

    assign beat_last = (count_reg + CNT_W'(1)) == f_reg;

    // Average: divide |acc| by F, restore the sign (truncation toward zero),
    // then floor-shift by W and saturate to the signed unit range.
    always_comb begin
        acc_mag  = acc_reg[ACC_W-1] ? ACC_W'(-acc_reg) : ACC_W'(acc_reg);
        q_signed = acc_reg[ACC_W-1] ? -$signed(div_quotient) : $signed(div_quotient);
        q_shift  = q_signed >>> UNIT_W;
        q_fits   = (&q_shift[ACC_W-1:UNIT_W-1]) | ~(|q_shift[ACC_W-1:UNIT_W-1]);
        if (q_fits) begin
            avg_sat = q_shift[UNIT_W-1:0];
        end else if (q_shift[ACC_W-1]) begin
            avg_sat = {1'b1, {(UNIT_W-1){1'b0}}};
        end else begin
            avg_sat = {1'b0, {(UNIT_W-1){1'b1}}};
        end
    end

    // Window decode. The lower-bound test wins, so an inverted window never
    // reaches the scaling divide and its divisor is always positive.
    always_comb begin
        clamp_low   = avg_reg < lower_reg;
        clamp_high  = avg_reg > upper_reg;
        zero_window = upper_reg == lower_reg;
        go_scale    = !clamp_low && !clamp_high && !zero_window;
        scale_num   = ($signed({{EXT_W{avg_reg[UNIT_W-1]}}, avg_reg})
                     - $signed({{EXT_W{lower_reg[UNIT_W-1]}}, lower_reg})) <<< UNIT_W;
        scale_den   = $signed({{EXT_W{upper_reg[UNIT_W-1]}}, upper_reg})
                     - $signed({{EXT_W{lower_reg[UNIT_W-1]}}, lower_reg});
        scale_sat   = (|div_quotient[ACC_W-1:UNIT_W]) ? {UNIT_W{1'b1}} : div_quotient[UNIT_W-1:0];
    end

    // The scaling divide is loaded from CLAMP itself, so DIV_SCALE holds
    // only the iterations; the averaging divide is loaded from DIV_AVG's
    // first cycle, after the final product has landed in acc.
    always_comb begin
        if (state_reg == ST_CLAMP) begin
            div_dividend = ACC_W'(scale_num);
            div_divisor  = ACC_W'(scale_den);
        end else begin
            div_dividend = acc_mag;
            div_divisor  = {{(ACC_W-CNT_W){1'b0}}, f_reg};
        end
    end

    seq_divider #(.DW(ACC_W)) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (bus.in_valid) state_next = (f_first == CNT_W'(1)) ? ST_DIV_AVG : ST_MAC;
            ST_MAC:       if (bus.in_valid && beat_last) state_next = ST_DIV_AVG;
            ST_DIV_AVG:   if (div_done) state_next = ST_CLAMP;
            ST_CLAMP:     state_next = go_scale ? ST_DIV_SCALE : ST_DONE;
            ST_DIV_SCALE: if (div_done) state_next = ST_DONE;
            ST_DONE:      if (bus.out_ready) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_MAC);
        out_valid = state_reg == ST_DONE;
        busy      = state_reg != ST_IDLE;
        div_start = ((state_reg == ST_DIV_AVG) && !div_launched_reg)
                  || ((state_reg == ST_CLAMP) && go_scale);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg          <= '0;
            count_reg        <= '0;
            f_reg            <= '0;
            upper_reg        <= '0;
            lower_reg        <= '0;
            avg_reg          <= '0;
            data_reg         <= '0;
            too_big_reg      <= 1'b0;
            too_small_reg    <= 1'b0;
            div_launched_reg <= 1'b0;
        end else begin
            div_launched_reg <= state_reg == ST_DIV_AVG;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        acc_reg   <= product;
                        count_reg <= CNT_W'(1);
                        f_reg     <= f_first;
                        upper_reg <= $signed(bus.cfg_upper);
                        lower_reg <= $signed(bus.cfg_lower);
                    end
                end
                ST_MAC: begin
                    if (bus.in_valid) begin
                        acc_reg   <= acc_reg + product;
                        count_reg <= count_reg + CNT_W'(1);
                    end
                end
                ST_DIV_AVG: begin
                    if (div_done) avg_reg <= avg_sat;
                end
                ST_CLAMP: begin
                    // Zero window and scaled paths both start from data 0.
                    data_reg      <= (!clamp_low && clamp_high) ? {UNIT_W{1'b1}} : {UNIT_W{1'b0}};
                    too_small_reg <= clamp_low;
                    too_big_reg   <= !clamp_low && clamp_high;
                end
                ST_DIV_SCALE: begin
                    if (div_done) data_reg <= scale_sat;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid;
    assign bus.busy          = busy;
    assign bus.out_data      = data_reg;
    assign bus.out_average   = avg_reg;
    assign bus.out_too_big   = too_big_reg;
    assign bus.out_too_small = too_small_reg;

endmodule
